// File: rtl/act_pingpong_buffer_pkg.sv
// Shared defaults and state encoding for the ping-pong activation buffer.
package act_pingpong_buffer_pkg;

  localparam int DEPTH_DEF  = 1024;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LAYER = 2'b01,
    ST_SWAP  = 2'b10
  } state_e;

endpackage

// File: rtl/act_bank_ram.sv
// Single-port synchronous RAM with registered read; a read that hits the
// address being written returns the old word.
module act_bank_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int AW     = 10
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [AW-1:0]            addr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  output logic signed [DATA_W-1:0] rdata_o
);

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic signed [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/act_pingpong_buffer.sv
// Double-banked activation buffer: layers read the source bank and write the
// destination bank; the banks swap when a layer signals completion.
module act_pingpong_buffer
  import act_pingpong_buffer_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     layer_start,
  input  logic                     layer_done,
  input  logic [ADDR_W-1:0]        input_addr,
  output logic signed [DATA_W-1:0] input_data,
  input  logic [ADDR_W-1:0]        output_addr,
  input  logic signed [DATA_W-1:0] output_data,
  input  logic                     write_enable,
  input  logic                     host_we,
  input  logic [ADDR_W-1:0]        host_addr,
  input  logic signed [DATA_W-1:0] host_wdata,
  output logic signed [DATA_W-1:0] host_rdata,
  output logic                     busy,
  output logic                     src_bank,
  output logic [ADDR_W-1:0]        src_len,
  output logic                     oob_err,
  output logic                     host_conflict
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic                src_bank_q, src_bank_d;
  logic [ADDR_W-1:0]   src_len_q, src_len_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic                oob_q, oob_d;
  logic                conf_q, conf_d;

  logic                in_vld_p1, host_vld_p1;
  logic                rd_bank_p1, in_oob_p1, host_oob_p1;
  logic signed [DATA_W-1:0] in_hold_q, host_hold_q;

  logic                is_idle, is_layer;
  logic                in_ok, out_ok, host_ok, wr_ok;

  logic                     ram_en    [2];
  logic                     ram_we    [2];
  logic [AW-1:0]            ram_addr  [2];
  logic signed [DATA_W-1:0] ram_wdata [2];
  logic signed [DATA_W-1:0] ram_rdata [2];

  assign is_idle  = (state_q == ST_IDLE);
  assign is_layer = (state_q == ST_LAYER);
  assign in_ok    = ({1'b0, input_addr}  < DEPTH_X);
  assign out_ok   = ({1'b0, output_addr} < DEPTH_X);
  assign host_ok  = ({1'b0, host_addr}   < DEPTH_X);
  assign wr_ok    = is_layer && write_enable && out_ok;

  // Source bank serves the host in IDLE and layer reads in LAYER; the other
  // bank only ever takes layer writes.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      ram_en[b]    = 1'b0;
      ram_we[b]    = 1'b0;
      ram_addr[b]  = '0;
      ram_wdata[b] = '0;
      if (!reset) begin
        if (src_bank_q == b[0]) begin
          if (is_idle) begin
            ram_en[b]    = host_ok;
            ram_we[b]    = host_we;
            ram_addr[b]  = host_addr[AW-1:0];
            ram_wdata[b] = host_wdata;
          end else if (is_layer) begin
            ram_en[b]   = in_ok;
            ram_addr[b] = input_addr[AW-1:0];
          end
        end else if (wr_ok) begin
          ram_en[b]    = 1'b1;
          ram_we[b]    = 1'b1;
          ram_addr[b]  = output_addr[AW-1:0];
          ram_wdata[b] = output_data;
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    act_bank_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (AW)
    ) u_bank (
      .clk     (clk),
      .en_i    (ram_en[g]),
      .we_i    (ram_we[g]),
      .addr_i  (ram_addr[g]),
      .wdata_i (ram_wdata[g]),
      .rdata_o (ram_rdata[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    src_bank_d = src_bank_q;
    src_len_d  = src_len_q;
    wr_cnt_d   = wr_cnt_q;
    oob_d      = oob_q;
    conf_d     = conf_q;
    case (state_q)
      ST_IDLE: begin
        if (!host_ok) oob_d = 1'b1;
        if (layer_start) begin
          state_d  = ST_LAYER;
          wr_cnt_d = '0;
        end
      end
      ST_LAYER: begin
        if (!in_ok || (write_enable && !out_ok)) oob_d = 1'b1;
        if (host_we) conf_d = 1'b1;
        if (wr_ok) wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        if (layer_done) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        if (host_we) conf_d = 1'b1;
        src_bank_d = ~src_bank_q;
        src_len_d  = wr_cnt_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      src_bank_q  <= 1'b0;
      src_len_q   <= '0;
      wr_cnt_q    <= '0;
      oob_q       <= 1'b0;
      conf_q      <= 1'b0;
      in_vld_p1   <= 1'b0;
      host_vld_p1 <= 1'b0;
      in_hold_q   <= '0;
      host_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      src_bank_q  <= src_bank_d;
      src_len_q   <= src_len_d;
      wr_cnt_q    <= wr_cnt_d;
      oob_q       <= oob_d;
      conf_q      <= conf_d;
      in_vld_p1   <= is_layer;
      host_vld_p1 <= is_idle;
      in_hold_q   <= input_data;
      host_hold_q <= host_rdata;
    end
  end

  // Read stage p1: which bank answered and whether the address was out of range.
  always_ff @(posedge clk) begin
    rd_bank_p1  <= src_bank_q;
    in_oob_p1   <= ~in_ok;
    host_oob_p1 <= ~host_ok;
  end

  assign input_data = in_vld_p1 ? (in_oob_p1 ? '0 : ram_rdata[rd_bank_p1]) : in_hold_q;
  assign host_rdata = host_vld_p1 ? (host_oob_p1 ? '0 : ram_rdata[rd_bank_p1]) : host_hold_q;

  assign busy          = (state_q != ST_IDLE);
  assign src_bank      = src_bank_q;
  assign src_len       = src_len_q;
  assign oob_err       = oob_q;
  assign host_conflict = conf_q;

endmodule
